// File: rtl/icache_pkg.sv
// Shared types and derived-width helpers for the L1 instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_FILL
    } state_t;

    function automatic int off_bits(input int bytes);
        return $clog2(bytes);
    endfunction

    function automatic int set_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int sets, input int bytes);
        return 32 - $clog2(sets) - $clog2(bytes);
    endfunction

    function automatic int beats(input int bytes, input int width);
        return (8 * bytes) / width;
    endfunction

    function automatic int cnt_bits(input int bytes, input int width);
        return (beats(bytes, width) > 1) ? $clog2(beats(bytes, width)) : 1;
    endfunction

    function automatic int age_bits(input int ways);
        return $clog2(ways);
    endfunction

endpackage

// File: rtl/icache_lru_ages.sv
// Per-set true-LRU age counters and victim selection (invalid ways first).
module icache_lru_ages
    import icache_pkg::*;
#(
    parameter int S = 32,
    parameter int E = 4
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 access,
    input  logic [$clog2(S)-1:0] aset,
    input  logic [$clog2(E)-1:0] away,
    input  logic [$clog2(S)-1:0] vset,
    input  logic [E-1:0]         vvalid,
    output logic [$clog2(E)-1:0] victim
);

    localparam int AW = age_bits(E);

    logic [AW-1:0] ages_q [S][E];
    logic [AW-1:0] old_age;

    assign old_age = ages_q[aset][away];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < S; i++)
                for (int j = 0; j < E; j++)
                    ages_q[i][j] <= AW'(j);
        end else if (access) begin
            for (int j = 0; j < E; j++) begin
                if (AW'(j) == away)
                    ages_q[aset][j] <= '0;
                else if (ages_q[aset][j] < old_age)
                    ages_q[aset][j] <= ages_q[aset][j] + AW'(1);
            end
        end
    end

    always_comb begin
        logic          found;
        logic [AW-1:0] best;
        victim = '0;
        found  = 1'b0;
        best   = ages_q[vset][0];
        for (int j = 0; j < E; j++) begin
            if (!found && !vvalid[j]) begin
                victim = AW'(j);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int j = 1; j < E; j++) begin
                if (ages_q[vset][j] > best) begin
                    best   = ages_q[vset][j];
                    victim = AW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/icache_l1_refill.sv
// Blocking L1 I-cache with built-in line refill engine and fence.i flush.
// Optional hit/miss counters: define ICACHE_PERF_CNT_EN.
module icache_l1_refill
    import icache_pkg::*;
#(
    parameter int S = 32,
    parameter int E = 4,
    parameter int B = 64,
    parameter int W = 64
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          FetchValid,
    input  logic [31:0]   Address,
    input  logic          Flush,
    output logic [31:0]   RD,
    output logic          Hit,
    output logic          L1IMiss,
    output logic          MemReqValid,
    input  logic          MemReqReady,
    output logic [31:0]   MemReqAddr,
    input  logic          MemRspValid,
    input  logic [W-1:0]  MemRspData,
    output logic          RefillActive
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]   HitCount,
    output logic [31:0]   MissCount
`endif
);

    localparam int OB = off_bits(B);
    localparam int SB = set_bits(S);
    localparam int TB = tag_bits(S, B);
    localparam int NB = beats(B, W);
    localparam int CB = cnt_bits(B, W);
    localparam int AW = age_bits(E);
    localparam int WB = $clog2(W);
    localparam int LB = 8 * B;

    state_t state_q, state_d;

    logic [E-1:0]     valid_q [S];
    logic [TB-1:0]    tag_q   [S][E];
    logic [LB-1:0]    data_q  [S][E];

    logic [TB+SB-1:0] lnum_q;
    logic [AW-1:0]    vway_q;
    logic [CB-1:0]    cnt_q;
    logic             pend_q;

    logic [SB-1:0]    set_a, fset;
    logic [TB-1:0]    tag_a, ftag;
    logic [OB+2:0]    sh;
    logic [E-1:0]     hitv;
    logic [AW-1:0]    hway, victim;
    logic             idle, miss_go, req_go;
    logic             beat, last, flush_now;

    assign set_a = Address[SB+OB-1:OB];
    assign tag_a = Address[31:SB+OB];
    assign sh    = {Address[OB-1:0] & ~OB'(3), 3'b000};
    assign fset  = lnum_q[SB-1:0];
    assign ftag  = lnum_q[TB+SB-1:SB];

    always_comb begin
        hitv = '0;
        hway = '0;
        for (int j = E - 1; j >= 0; j--) begin
            hitv[j] = valid_q[set_a][j] && (tag_q[set_a][j] == tag_a);
            if (hitv[j])
                hway = AW'(j);
        end
    end

    assign idle      = (state_q == ST_IDLE);
    assign Hit       = FetchValid & idle & (|hitv);
    assign L1IMiss   = FetchValid & ~Hit;
    assign RD        = Hit ? data_q[set_a][hway][sh +: 32] : '0;
    assign miss_go   = FetchValid & idle & ~(|hitv);
    assign req_go    = (state_q == ST_REQ) & MemReqReady;
    assign beat      = (state_q == ST_FILL) & MemRspValid;
    assign last      = beat & (cnt_q == CB'(NB - 1));
    // A flush seen mid-refill waits for the install, then wipes everything.
    assign flush_now = (idle & Flush) | (last & (pend_q | Flush));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (miss_go) state_d = ST_REQ;
            ST_REQ:  if (MemReqReady) state_d = ST_FILL;
            ST_FILL: if (last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        MemReqValid  = 1'b0;
        RefillActive = 1'b0;
        unique case (state_q)
            ST_IDLE: ;
            ST_REQ: begin
                MemReqValid  = 1'b1;
                RefillActive = 1'b1;
            end
            ST_FILL: RefillActive = 1'b1;
            default: ;
        endcase
    end

    assign MemReqAddr = MemReqValid ? {lnum_q, {OB{1'b0}}} : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lnum_q <= '0;
            vway_q <= '0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
            for (int i = 0; i < S; i++)
                valid_q[i] <= '0;
        end else begin
            if (miss_go) begin
                lnum_q <= Address[31:OB];
                vway_q <= victim;
            end
            if (req_go)
                cnt_q <= '0;
            else if (beat)
                cnt_q <= cnt_q + CB'(1);
            if (last)
                pend_q <= 1'b0;
            else if (!idle && Flush)
                pend_q <= 1'b1;
            if (flush_now) begin
                for (int i = 0; i < S; i++)
                    valid_q[i] <= '0;
            end else begin
                if (miss_go)
                    valid_q[set_a][victim] <= 1'b0;
                if (last)
                    valid_q[fset][vway_q] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (beat)
            data_q[fset][vway_q][{cnt_q, {WB{1'b0}}} +: W] <= MemRspData;
        if (last)
            tag_q[fset][vway_q] <= ftag;
    end

    icache_lru_ages #(
        .S(S),
        .E(E)
    ) u_lru (
        .clk    (clk),
        .reset  (reset),
        .access (Hit | last),
        .aset   (last ? fset : set_a),
        .away   (last ? vway_q : hway),
        .vset   (set_a),
        .vvalid (valid_q[set_a]),
        .victim (victim)
    );

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            HitCount  <= '0;
            MissCount <= '0;
        end else begin
            if (Hit)
                HitCount <= HitCount + 32'd1;
            if (miss_go)
                MissCount <= MissCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_l1_refill.sv
// Scoreboard bench for icache_l1_refill (default parameters, W=64).
module tb_icache_l1_refill;

    logic        clk = 1'b0;
    logic        reset;
    logic        FetchValid;
    logic [31:0] Address;
    logic        Flush;
    logic [31:0] RD;
    logic        Hit;
    logic        L1IMiss;
    logic        MemReqValid;
    logic        MemReqReady;
    logic [31:0] MemReqAddr;
    logic        MemRspValid;
    logic [63:0] MemRspData;
    logic        RefillActive;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] HitCount;
    logic [31:0] MissCount;
`endif

    icache_l1_refill dut (
        .clk          (clk),
        .reset        (reset),
        .FetchValid   (FetchValid),
        .Address      (Address),
        .Flush        (Flush),
        .RD           (RD),
        .Hit          (Hit),
        .L1IMiss      (L1IMiss),
        .MemReqValid  (MemReqValid),
        .MemReqReady  (MemReqReady),
        .MemReqAddr   (MemReqAddr),
        .MemRspValid  (MemRspValid),
        .MemRspData   (MemRspData),
        .RefillActive (RefillActive)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .HitCount     (HitCount),
        .MissCount    (MissCount)
`endif
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;
    logic [31:0] exp_rd  [$];
    logic [31:0] exp_req [$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // Word j of the line at base holds (base>>4)+j.
    function automatic logic [31:0] wv(input logic [31:0] base, input int j);
        return (base >> 4) + 32'(j);
    endfunction

    always @(negedge clk) begin
        if (!reset && Hit) begin
            if (exp_rd.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected hit: RD=%h addr=%h want no hit",
                         RD, Address);
            end else begin
                chk("hit data", RD, exp_rd.pop_front());
            end
        end
        if (!reset && MemReqValid && MemReqReady) begin
            if (exp_req.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected request: addr=%h want none",
                         MemReqAddr);
            end else begin
                chk("request addr", MemReqAddr, exp_req.pop_front());
            end
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_hit(input logic [31:0] a, input logic [31:0] line);
        FetchValid = 1'b1;
        Address    = a;
        exp_rd.push_back(wv(line, int'(a[5:2])));
        #1;
        chk1("hit flag", Hit, 1'b1);
        chk1("no stall on hit", L1IMiss, 1'b0);
        adv();
        FetchValid = 1'b0;
    endtask

    task automatic fetch_miss(input logic [31:0] a);
        FetchValid = 1'b1;
        Address    = a;
        exp_req.push_back(a & 32'hFFFF_FFC0);
        #1;
        chk1("miss stall", L1IMiss, 1'b1);
        chk1("miss no hit", Hit, 1'b0);
        adv();
        FetchValid = 1'b0;
    endtask

    task automatic refill(input logic [31:0] line, input int rdy_dly,
                          input int gap, input bit present, input int flush_k);
        if (present) begin
            FetchValid = 1'b1;
            Address    = line;
        end
        for (int i = 0; i < rdy_dly; i++) begin
            #1;
            chk1("req valid held", MemReqValid, 1'b1);
            chk("req addr held", MemReqAddr, line);
            if (present)
                chk1("hit blocked in req", Hit, 1'b0);
            adv();
        end
        MemReqReady = 1'b1;
        #1;
        chk1("req valid", MemReqValid, 1'b1);
        chk1("active in req", RefillActive, 1'b1);
        adv();
        MemReqReady = 1'b0;
        for (int k = 0; k < 8; k++) begin
            MemRspValid = 1'b1;
            MemRspData  = {wv(line, 2 * k + 1), wv(line, 2 * k)};
            Flush       = (k == flush_k);
            #1;
            chk1("active in fill", RefillActive, 1'b1);
            if (present)
                chk1("hit blocked in fill", Hit, 1'b0);
            adv();
            MemRspValid = 1'b0;
            Flush       = 1'b0;
            if (k < 7) begin
                for (int g = 0; g < gap; g++) begin
                    #1;
                    if (present)
                        chk1("hit blocked in gap", Hit, 1'b0);
                    adv();
                end
            end
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        FetchValid = 1'b0;
        adv();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        FetchValid  = 1'b1;
        Address     = 32'h1000;
        Flush       = 1'b0;
        MemReqReady = 1'b0;
        MemRspValid = 1'b0;
        MemRspData  = '0;
        #2;
        chk1("reset hit", Hit, 1'b0);
        chk("reset rd", RD, 32'h0);
        chk1("reset stall", L1IMiss, 1'b1);
        chk1("reset req valid", MemReqValid, 1'b0);
        chk("reset req addr", MemReqAddr, 32'h0);
        chk1("reset active", RefillActive, 1'b0);
        adv();
        FetchValid = 1'b0;
        reset      = 1'b0;

        // cold miss and word select
        fetch_miss(32'h1000);
        refill(32'h1000, 0, 0, 1'b0, -1);
        fetch_hit(32'h1000, 32'h1000);
        fetch_hit(32'h1004, 32'h1000);
        fetch_hit(32'h103C, 32'h1000);
`ifdef ICACHE_PERF_CNT_EN
        chk("miss count", MissCount, 32'd1);
        chk("hit count", HitCount, 32'd3);
`endif

        // flush in idle: same-cycle hit, then miss
        FetchValid = 1'b1;
        Address    = 32'h1000;
        Flush      = 1'b1;
        exp_rd.push_back(32'h100);
        #1;
        chk1("hit during flush", Hit, 1'b1);
        adv();
        Flush      = 1'b0;
        FetchValid = 1'b0;
        fetch_miss(32'h1000);
        refill(32'h1000, 0, 0, 1'b0, -1);
        fetch_hit(32'h1008, 32'h1000);

        // LRU replacement in set 0
        do_reset();
        fetch_miss(32'h0000);
        refill(32'h0000, 0, 0, 1'b0, -1);
        fetch_miss(32'h0800);
        refill(32'h0800, 0, 0, 1'b0, -1);
        fetch_miss(32'h1000);
        refill(32'h1000, 0, 0, 1'b0, -1);
        fetch_miss(32'h1800);
        refill(32'h1800, 0, 0, 1'b0, -1);
        fetch_hit(32'h0008, 32'h0000);
        fetch_miss(32'h2000);
        refill(32'h2000, 0, 0, 1'b0, -1);
        fetch_hit(32'h2004, 32'h2000);
        fetch_miss(32'h0800);
        refill(32'h0800, 0, 0, 1'b0, -1);
        fetch_hit(32'h0804, 32'h0800);
        fetch_hit(32'h000C, 32'h0000);

        // backpressure, gapped beats, stray beats in idle
        fetch_miss(32'h3040);
        refill(32'h3040, 5, 1, 1'b1, -1);
        fetch_hit(32'h307C, 32'h3040);
        for (int i = 0; i < 3; i++) begin
            MemRspValid = 1'b1;
            MemRspData  = 64'hDEAD_BEEF_0BAD_F00D;
            #1;
            chk1("idle beat active", RefillActive, 1'b0);
            chk1("idle beat req", MemReqValid, 1'b0);
            adv();
        end
        MemRspValid = 1'b0;
        fetch_hit(32'h3040, 32'h3040);

        // flush during fill
        fetch_miss(32'h4080);
        refill(32'h4080, 0, 0, 1'b0, 4);
        #1;
        chk1("active falls after fill", RefillActive, 1'b0);
        fetch_miss(32'h4080);
        refill(32'h4080, 0, 0, 1'b0, -1);
        fetch_hit(32'h4084, 32'h4080);

        // reset mid-fill
        fetch_miss(32'h50C0);
        MemReqReady = 1'b1;
        adv();
        MemReqReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            MemRspValid = 1'b1;
            MemRspData  = {wv(32'h50C0, 2 * k + 1), wv(32'h50C0, 2 * k)};
            adv();
        end
        MemRspValid = 1'b0;
        FetchValid  = 1'b1;
        Address     = 32'h50C0;
        reset       = 1'b1;
        #1;
        chk1("mid-fill reset req", MemReqValid, 1'b0);
        chk1("mid-fill reset active", RefillActive, 1'b0);
        chk("mid-fill reset addr", MemReqAddr, 32'h0);
        chk1("mid-fill reset hit", Hit, 1'b0);
        chk1("mid-fill reset stall", L1IMiss, 1'b1);
        adv();
        reset      = 1'b0;
        FetchValid = 1'b0;
        for (int k = 3; k < 8; k++) begin
            MemRspValid = 1'b1;
            MemRspData  = {wv(32'h50C0, 2 * k + 1), wv(32'h50C0, 2 * k)};
            #1;
            chk1("late beat active", RefillActive, 1'b0);
            adv();
        end
        MemRspValid = 1'b0;
        fetch_miss(32'h50C0);
        refill(32'h50C0, 0, 0, 1'b0, -1);
        fetch_hit(32'h50C8, 32'h50C0);

        adv();
        chk("pending hit expectations", exp_rd.size(), 32'd0);
        chk("pending request expectations", exp_req.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
